// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: FSM encodings, segment
// bit positions and the counter-width helper.
package seg7_scan_ctrl_pkg;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DISP  = 1'b1;

  localparam logic [7:0]  SEG_OFF   = 8'h00;
  localparam int unsigned DP_BIT    = 7;
  localparam int unsigned BCD_WIDTH = 4;

  // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Frame-load handshake between the application (master) and the scan
// controller (slave).
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_blank;
  logic [NUM_DIGITS-1:0]   load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_blank,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_blank,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder, segments {g,f,e,d,c,b,a}, 1 = on.
// Codes 10..15 light nothing.
module seg7_decoder
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [BCD_WIDTH-1:0] bcd,
  output logic [6:0]           seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-cathode display with a
// double-buffered frame that is swapped only at the frame boundary.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DWELL_CYC  = 50000,
  parameter int unsigned BLANK_CYC  = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_ctrl_if.slave       load,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] com_n,
  output logic                  frame_done
);

  localparam int unsigned CntW  = cnt_width(DWELL_CYC, BLANK_CYC);
  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned DataW = BCD_WIDTH * NUM_DIGITS;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYC - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            lead_q, lead_d;
  logic            wrap;

  logic [DataW-1:0]      active_data_q, pend_data_q;
  logic [NUM_DIGITS-1:0] active_blank_q, pend_blank_q;
  logic [NUM_DIGITS-1:0] active_dp_q, pend_dp_q;
  logic                  pend_full_q;
  logic                  accept, copy;

  logic [BCD_WIDTH-1:0]  nibble;
  logic [6:0]            glyph;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] com_n_d;

  // The reset BLANK period is a lead-in: it leaves idx at 0 so the first lit
  // digit is digit 0, and it is not a frame boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    lead_d  = lead_q;
    wrap    = 1'b0;
    case (state_q)
      ST_DISP: begin
        if (cnt_q == DwellLast) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BlankLast) begin
          state_d = ST_DISP;
          cnt_d   = '0;
          lead_d  = 1'b0;
          if (!lead_q) begin
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      lead_q     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lead_q     <= lead_d;
      frame_done <= wrap;
    end
  end

  // A full pending slot blocks accepts, so an accept and a copy are never
  // simultaneous; an accept on a wrap with an empty slot waits for the next wrap.
  assign load.load_ready = ~pend_full_q;
  assign accept          = load.load_valid & ~pend_full_q;
  assign copy            = wrap & pend_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q    <= 1'b0;
      pend_data_q    <= '0;
      pend_blank_q   <= '0;
      pend_dp_q      <= '0;
      active_data_q  <= '0;
      active_blank_q <= '1;
      active_dp_q    <= '0;
    end else begin
      if (accept) begin
        pend_full_q  <= 1'b1;
        pend_data_q  <= load.load_data;
        pend_blank_q <= load.load_blank;
        pend_dp_q    <= load.load_dp;
      end else if (copy) begin
        pend_full_q    <= 1'b0;
        active_data_q  <= pend_data_q;
        active_blank_q <= pend_blank_q;
        active_dp_q    <= pend_dp_q;
      end
    end
  end

  assign nibble = active_data_q[idx_q*BCD_WIDTH +: BCD_WIDTH];

  seg7_decoder u_decoder (
    .bcd (nibble),
    .seg (glyph)
  );

  always_comb begin
    seg_d   = SEG_OFF;
    com_n_d = '1;
    if (state_q == ST_DISP) begin
      com_n_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!active_blank_q[idx_q]) begin
        seg_d[6:0]    = glyph;
        seg_d[DP_BIT] = active_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_OFF;
      com_n <= '1;
    end else begin
      seg   <= seg_d;
      com_n <= com_n_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame/timeline reference model.
module tb_seg7_scan_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam int unsigned B = 2;
  localparam int unsigned P = N * (D + B);

  typedef struct packed {
    logic [4*N-1:0] data;
    logic [N-1:0]   blank;
    logic [N-1:0]   dp;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   seg;
  logic [N-1:0] com_n;
  logic         frame_done;

  logic   drv_valid;
  frame_t drv_frame;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) load_if ();

  assign load_if.load_valid = drv_valid;
  assign load_if.load_data  = drv_frame.data;
  assign load_if.load_blank = drv_frame.blank;
  assign load_if.load_dp    = drv_frame.dp;

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .DWELL_CYC  (D),
    .BLANK_CYC  (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_if.slave),
    .seg        (seg),
    .com_n      (com_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge count since reset release, the shown frame and a
  // one-deep queue of frames waiting for a frame boundary.
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  int     c;
  frame_t active_m;
  frame_t pend_m [$];
  bit     acc_flag;

  function automatic logic [7:0] ref_seg(input frame_t f, input int d);
    int v;
    if (f.blank[d]) return 8'h00;
    v = int'(f.data[4*d +: 4]);
    return {f.dp[d], glyph_tab[v]};
  endfunction

  // Scan timeline after k edges: B-cycle lead-in, then per digit D lit + B dark.
  function automatic bit lit_at(input int k, output int d);
    int pos;
    d = 0;
    if (k < int'(B)) return 1'b0;
    pos = (k - int'(B)) % int'(P);
    d   = pos / int'(D + B);
    return (pos % int'(D + B)) < int'(D);
  endfunction

  function automatic bit wrap_at(input int k);
    return (k > int'(B)) && (((k - int'(B)) % int'(P)) == 0);
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.data  = (4*N)'($urandom);
    f.blank = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    f.dp    = N'($urandom);
    return f;
  endfunction

  task automatic model_reset();
    c              = 0;
    active_m       = '0;
    active_m.blank = '1;
    pend_m.delete();
    drv_valid      = 1'b0;
  endtask

  task automatic step();
    bit           lit;
    int           d;
    logic [7:0]   e_seg;
    logic [N-1:0] e_com;
    bit           e_fd;
    @(posedge clk);
    c++;
    lit      = lit_at(c - 1, d);
    e_com    = lit ? ~(N'(1) << d) : '1;
    e_seg    = lit ? ref_seg(active_m, d) : 8'h00;
    e_fd     = wrap_at(c);
    acc_flag = 1'b0;
    if (wrap_at(c) && pend_m.size() > 0) begin
      active_m = pend_m.pop_front();
    end else if (drv_valid && pend_m.size() == 0) begin
      pend_m.push_back(drv_frame);
      acc_flag = 1'b1;
    end
    @(negedge clk);
    check_value("com_n", 32'(com_n), 32'(e_com));
    check_value("seg", 32'(seg), 32'(e_seg));
    check_value("frame_done", 32'(frame_done), 32'(e_fd));
    check_value("load_ready", 32'(load_if.load_ready), 32'(pend_m.size() == 0));
    check_value("com_onehot", 32'($countones(~com_n) <= 1), 32'd1);
  endtask

  task automatic offer(input frame_t f);
    bit done;
    done      = 1'b0;
    drv_frame = f;
    drv_valid = 1'b1;
    for (int i = 0; i < 4 * int'(P) && !done; i++) begin
      step();
      done = acc_flag;
    end
    if (!done) check_value("accept_timeout", 32'd0, 32'd1);
    drv_valid = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check_value({tag, "_com_n"}, 32'(com_n), 32'(N'('1)));
    check_value({tag, "_seg"}, 32'(seg), 32'd0);
    check_value({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_value({tag, "_load_ready"}, 32'(load_if.load_ready), 32'd1);
  endtask

  initial begin
    frame_t f;
    bit     hit;
    int     dd;
    drv_frame = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_dark("reset");
    rst_n = 1'b1;

    // Idle scan of the blank frame.
    repeat (2 * P + 10) step();

    // Known frame 4321 with the dp on digit 1.
    f = '{data: 16'h4321, blank: 4'b0000, dp: 4'b0010};
    offer(f);
    repeat (2 * P) step();

    // Back-to-back loads: the second waits for the slot to free.
    offer(rand_frame());
    offer(rand_frame());
    repeat (2 * P) step();

    // Code A on digit 0, digit 2 forced blank.
    f = '{data: 16'h759A, blank: 4'b0100, dp: 4'b1000};
    offer(f);
    repeat (2 * P) step();

    // Random offers; the sender holds each frame until it is taken.
    for (int i = 0; i < 300; i++) begin
      if (!drv_valid && $urandom_range(0, 3) == 0) begin
        drv_frame = rand_frame();
        drv_valid = 1'b1;
      end
      step();
      if (acc_flag) drv_valid = 1'b0;
    end
    drv_valid = 1'b0;

    // Accept landing on the wrap edge itself.
    hit = 1'b0;
    for (int i = 0; i < 4 * int'(P) && !hit; i++) begin
      if (pend_m.size() == 0 && wrap_at(c + 1)) hit = 1'b1;
      else step();
    end
    check_value("wrap_align_found", 32'(hit), 32'd1);
    offer(rand_frame());
    repeat (2 * P + 2) step();

    // Reset asserted while a digit is lit.
    hit = 1'b0;
    for (int i = 0; i < 2 * int'(P) && !hit; i++) begin
      step();
      hit = lit_at(c - 1, dd);
    end
    check_value("mid_disp_found", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (P + 10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
